// File: rtl/dec_seq_pkg.sv
// Shared types for the decoder select sequencer: scan modes, FSM states, step direction.
package dec_seq_pkg;

    localparam int unsigned SEL_W_DEF = 3;
    localparam int unsigned DIV_W_DEF = 16;

    typedef enum logic [1:0] {
        MODE_UP  = 2'b00,
        MODE_DN  = 2'b01,
        MODE_PP  = 2'b10,
        MODE_ONE = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

endpackage

// File: rtl/dec_sel_sequencer_if.sv
// Control and status bundle between the sequencer and its controller / decoder.
interface dec_sel_sequencer_if #(
    parameter int unsigned SEL_W = dec_seq_pkg::SEL_W_DEF,
    parameter int unsigned DIV_W = dec_seq_pkg::DIV_W_DEF
);

    logic             en;
    logic [1:0]       mode;
    logic             start;
    logic [DIV_W-1:0] div;
    logic             load;
    logic [SEL_W-1:0] load_val;
    logic [SEL_W-1:0] sel;
    logic             sel_vld;
    logic             wrap;
    logic             busy;

    modport master (
        output en, mode, start, div, load, load_val,
        input  sel, sel_vld, wrap, busy
    );

    modport slave (
        input  en, mode, start, div, load, load_val,
        output sel, sel_vld, wrap, busy
    );

endinterface

// File: rtl/dec_prescaler.sv
// Step-rate prescaler: one tick every div+1 running cycles, cleared when stopped or preloaded.
module dec_prescaler #(
    parameter int unsigned DIV_W = dec_seq_pkg::DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count_q, count_d;

    always_comb begin
        tick    = run && !clr && (count_q == div);
        count_d = count_q + DIV_W'(1);
        // ">=" also catches div shrinking below the count: restart without a tick
        if (clr || !run || (count_q >= div)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dec_sel_sequencer.sv
// Select-code generator feeding a 2**SEL_W-output decoder, with four scan modes.
module dec_sel_sequencer
    import dec_seq_pkg::*;
#(
    parameter int unsigned SEL_W = SEL_W_DEF,
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    dec_sel_sequencer_if.slave  bus
);

    localparam logic [SEL_W-1:0] SEL_MAX = '1;
    localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d, dir_eff;
    logic             pp_q, pp_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    mode_e            mode;

    assign mode = mode_e'(bus.mode);

    dec_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (!bus.en || bus.load),
        .run  (state_q == RUN),
        .div  (bus.div),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        pp_d    = pp_q;
        wrap_d  = 1'b0;
        dir_eff = dir_q;

        unique case (state_q)
            IDLE: begin
                dir_d = DIR_UP;
                pp_d  = 1'b0;
                if (bus.load) begin
                    sel_d = bus.load_val;
                end
                if (bus.en && ((mode != MODE_ONE) || bus.start)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    dir_d   = DIR_UP;
                    pp_d    = 1'b0;
                end else if (bus.load) begin
                    sel_d = bus.load_val;
                end else if (tick) begin
                    // pp_q remembers that the previous step was ping-pong, so dir_q is live
                    pp_d = (mode == MODE_PP);
                    unique case (mode)
                        MODE_UP: begin
                            sel_d  = sel_q + SEL_ONE;
                            wrap_d = (sel_q == SEL_MAX);
                        end
                        MODE_DN: begin
                            sel_d  = sel_q - SEL_ONE;
                            wrap_d = (sel_q == '0);
                        end
                        MODE_PP: begin
                            if (!pp_q) begin
                                dir_eff = (sel_q == SEL_MAX) ? DIR_DN : DIR_UP;
                            end
                            if (dir_eff == DIR_UP) begin
                                if (sel_q == SEL_MAX) begin
                                    dir_d  = DIR_DN;
                                    sel_d  = sel_q - SEL_ONE;
                                    wrap_d = 1'b1;
                                end else begin
                                    dir_d = DIR_UP;
                                    sel_d = sel_q + SEL_ONE;
                                end
                            end else begin
                                if (sel_q == '0) begin
                                    dir_d  = DIR_UP;
                                    sel_d  = sel_q + SEL_ONE;
                                    wrap_d = 1'b1;
                                end else begin
                                    dir_d = DIR_DN;
                                    sel_d = sel_q - SEL_ONE;
                                end
                            end
                        end
                        MODE_ONE: begin
                            if (sel_q == SEL_MAX) begin
                                sel_d   = '0;
                                wrap_d  = 1'b1;
                                state_d = IDLE;
                            end else begin
                                sel_d = sel_q + SEL_ONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            pp_q    <= 1'b0;
            sel_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pp_q    <= pp_d;
            sel_q   <= sel_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.wrap    = wrap_q;
    assign bus.busy    = (state_q == RUN);
    assign bus.sel_vld = (state_q == RUN);

endmodule

// File: tb/tb_dec_sel_sequencer.sv
// Scoreboard bench for dec_sel_sequencer: directed stimulus queues expected outputs per edge.
module tb_dec_sel_sequencer;

    typedef struct packed {
        logic [2:0] sel;
        logic       vld;
        logic       wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dec_sel_sequencer_if #(.SEL_W(3), .DIV_W(16)) bus ();

    dec_sel_sequencer #(
        .SEL_W (3),
        .DIV_W (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input exp_t e, input string tag);
        checks++;
        if (bus.sel !== e.sel || bus.sel_vld !== e.vld || bus.busy !== e.vld ||
            bus.wrap !== e.wrap) begin
            errors++;
            $display("FAIL %s: got sel=%0d vld=%0b busy=%0b wrap=%0b, want sel=%0d vld=%0b busy=%0b wrap=%0b",
                     tag, bus.sel, bus.sel_vld, bus.busy, bus.wrap, e.sel, e.vld, e.vld, e.wrap);
        end
    endtask

    // Monitor: one queued expectation per rising edge, sampled just after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            check(exp_q.pop_front(), tag_q.pop_front());
        end
    end

    // Called at a falling edge with inputs set; queues the result of the next rising edge.
    task automatic exp_cycle(input logic [2:0] s, input logic v, input logic w, input string tag);
        exp_t e;
        e.sel  = s;
        e.vld  = v;
        e.wrap = w;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    int pp_sel[17] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    int ld_sel[9]  = '{0, 0, 7, 7, 6, 6, 3, 3, 2};

    initial begin
        exp_t r;
        bus.en       = 1'b0;
        bus.mode     = 2'b00;
        bus.start    = 1'b0;
        bus.div      = 16'd0;
        bus.load     = 1'b0;
        bus.load_val = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r = '{sel: 3'd0, vld: 1'b0, wrap: 1'b0};
        check(r, "reset_state");

        // Up-wrap, div=2: each value held 3 cycles, wrap on 7->0
        bus.en = 1'b1; bus.mode = 2'b00; bus.div = 16'd2;
        for (int i = 0; i < 27; i++) begin
            exp_cycle(3'((i / 3) % 8), 1'b1, i == 24, "up_div2");
        end
        bus.en = 1'b0;
        exp_cycle(3'd0, 1'b0, 1'b0, "up_stop");
        exp_cycle(3'd0, 1'b0, 1'b0, "up_idle");

        // Enable drop at sel=6, then restart from 0
        bus.en = 1'b1; bus.div = 16'd0;
        for (int i = 0; i < 7; i++) exp_cycle(3'(i), 1'b1, 1'b0, "up_div0");
        bus.en = 1'b0;
        exp_cycle(3'd0, 1'b0, 1'b0, "en_drop_at6");
        bus.en = 1'b1;
        exp_cycle(3'd0, 1'b1, 1'b0, "restart_entry");
        exp_cycle(3'd1, 1'b1, 1'b0, "restart_step1");
        exp_cycle(3'd2, 1'b1, 1'b0, "restart_step2");
        bus.en = 1'b0;
        exp_cycle(3'd0, 1'b0, 1'b0, "restart_stop");

        // Ping-pong, div=0
        bus.en = 1'b1; bus.mode = 2'b10;
        for (int i = 0; i < 17; i++) begin
            exp_cycle(3'(pp_sel[i]), 1'b1, (i == 8) || (i == 15), "pingpong");
        end
        bus.en = 1'b0;
        exp_cycle(3'd0, 1'b0, 1'b0, "pingpong_stop");

        // Single-shot: waits for start, runs 0..7, ends in IDLE, ignores start while running
        bus.en = 1'b1; bus.mode = 2'b11;
        exp_cycle(3'd0, 1'b0, 1'b0, "oneshot_wait_start");
        bus.start = 1'b1;
        exp_cycle(3'd0, 1'b1, 1'b0, "oneshot_entry");
        for (int i = 1; i < 8; i++) begin
            bus.start = (i == 3);
            exp_cycle(3'(i), 1'b1, 1'b0, "oneshot_run");
        end
        bus.start = 1'b0;
        exp_cycle(3'd0, 1'b0, 1'b1, "oneshot_done");
        exp_cycle(3'd0, 1'b0, 1'b0, "oneshot_no_requeue");
        bus.en = 1'b0;
        exp_cycle(3'd0, 1'b0, 1'b0, "oneshot_idle");

        // Down-wrap, div=1; load of 3 collides with the tick that would give 5
        bus.en = 1'b1; bus.mode = 2'b01; bus.div = 16'd1;
        for (int i = 0; i < 9; i++) begin
            bus.load     = (i == 6);
            bus.load_val = 3'd3;
            exp_cycle(3'(ld_sel[i]), 1'b1, i == 2, "down_load");
        end
        bus.load = 1'b0; bus.en = 1'b0;
        exp_cycle(3'd0, 1'b0, 1'b0, "down_stop");

        // div shrinks from 9 to 2 while the count is at 5
        bus.en = 1'b1; bus.mode = 2'b00; bus.div = 16'd9;
        for (int i = 0; i < 13; i++) begin
            bus.div = (i >= 6) ? 16'd2 : 16'd9;
            exp_cycle((i < 9) ? 3'd0 : ((i < 12) ? 3'd1 : 3'd2), 1'b1, 1'b0, "div_shrink");
        end
        bus.en = 1'b0;
        exp_cycle(3'd0, 1'b0, 1'b0, "div_shrink_stop");

        // Preload in IDLE does not start; run then resumes from the loaded value
        bus.load = 1'b1; bus.load_val = 3'd5; bus.div = 16'd0;
        exp_cycle(3'd5, 1'b0, 1'b0, "idle_load");
        bus.load = 1'b0; bus.en = 1'b1;
        exp_cycle(3'd5, 1'b1, 1'b0, "run_from_load");

        // Asynchronous reset mid-run, checked before any further clock edge
        rst = 1'b1;
        #1;
        r = '{sel: 3'd0, vld: 1'b0, wrap: 1'b0};
        check(r, "async_reset_midrun");
        @(negedge clk);
        rst = 1'b0; bus.en = 1'b0;
        exp_cycle(3'd0, 1'b0, 1'b0, "post_reset_idle");

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
